// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode map, flag bit positions
// and the per-opcode mask of which architectural flags an op may update.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'b000,
    OP_SUB    = 3'b001,
    OP_XOR    = 3'b010,
    OP_RED    = 3'b011,
    OP_SLL    = 3'b100,
    OP_SRA    = 3'b101,
    OP_ROR    = 3'b110,
    OP_PADDSB = 3'b111
  } alu_op_e;

  localparam int FLG_N = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;

  localparam logic [2:0] MASK_NVZ  = 3'b111;
  localparam logic [2:0] MASK_Z    = 3'b100;
  localparam logic [2:0] MASK_NONE = 3'b000;

  // Arithmetic ops own all flags, logic/shift ops only Z, packed ops none.
  function automatic logic [2:0] op_flag_mask(input alu_op_e op);
    case (op)
      OP_ADD, OP_SUB:                 op_flag_mask = MASK_NVZ;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: op_flag_mask = MASK_Z;
      default:                        op_flag_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Purely combinational ALU core: computes the result, candidate N/V/Z flags
// and the flag update mask for one operation.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE   = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cand_flags,
  output logic [2:0]       mask
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / LANE;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             arith_ovf;
  logic [WIDTH-1:0] arith_res;
  logic [WIDTH-1:0] red_res;
  logic [WIDTH-1:0] paddsb_res;
  logic [LANE-1:0]  lane_a;
  logic [LANE-1:0]  lane_b;
  logic [LANE-1:0]  lane_s;

  assign shamt = b[SHW-1:0];

  // Signed add/sub sharing one adder; SUB inverts B and injects a carry.
  always_comb begin
    b_eff     = (op == OP_SUB) ? ~b : b;
    sum       = a + b_eff + WIDTH'(op == OP_SUB);
    arith_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    arith_res = sum;
    if (SAT_EN && arith_ovf) begin
      arith_res = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // Byte reduction: every byte of A and B is a signed 8-bit value.
  always_comb begin
    red_res = '0;
    for (int i = 0; i < NBYTES; i++) begin
      red_res = red_res + {{(WIDTH-8){a[8*i+7]}}, a[8*i +: 8]}
                        + {{(WIDTH-8){b[8*i+7]}}, b[8*i +: 8]};
    end
  end

  // Per-lane signed saturating add with no carry between lanes.
  always_comb begin
    paddsb_res = '0;
    lane_a     = '0;
    lane_b     = '0;
    lane_s     = '0;
    for (int j = 0; j < NLANES; j++) begin
      lane_a = a[j*LANE +: LANE];
      lane_b = b[j*LANE +: LANE];
      lane_s = lane_a + lane_b;
      if ((lane_a[LANE-1] == lane_b[LANE-1]) && (lane_s[LANE-1] != lane_a[LANE-1])) begin
        lane_s = lane_a[LANE-1] ? {1'b1, {(LANE-1){1'b0}}} : {1'b0, {(LANE-1){1'b1}}};
      end
      paddsb_res[j*LANE +: LANE] = lane_s;
    end
  end

  // Select the result for the opcode and derive candidate flags from it.
  always_comb begin
    case (op)
      OP_ADD, OP_SUB: result = arith_res;
      OP_XOR:         result = a ^ b;
      OP_RED:         result = red_res;
      OP_SLL:         result = a << shamt;
      OP_SRA:         result = $unsigned($signed(a) >>> shamt);
      OP_ROR:         result = (a >> shamt) | (a << (WIDTH - int'(shamt)));
      OP_PADDSB:      result = paddsb_res;
      default:        result = '0;
    endcase
    cand_flags        = '0;
    cand_flags[FLG_N] = result[WIDTH-1];
    cand_flags[FLG_V] = ((op == OP_ADD) || (op == OP_SUB)) ? arith_ovf : 1'b0;
    cand_flags[FLG_Z] = (result == '0);
    mask              = op_flag_mask(op);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with flush and an architectural N/V/Z
// flag register that commits on each output handshake.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE   = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [2:0]       out_flag
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic [2:0]       s2_cand;
  logic [2:0]       s2_mask;
  logic [2:0]       flag_q;
  logic [WIDTH-1:0] dp_result;
  logic [2:0]       dp_cand;
  logic [2:0]       dp_mask;
  logic             s2_free;
  logic             s1_load;
  logic             accept;
  logic             out_fire;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || s2_free;
  assign in_ready = !flush && s1_load;
  assign accept   = in_valid && in_ready;
  assign out_fire = s2_valid && out_ready;

  alu_datapath #(
    .WIDTH (WIDTH),
    .LANE  (LANE),
    .SAT_EN(SAT_EN)
  ) u_datapath (
    .op        (s1_op),
    .a         (s1_a),
    .b         (s1_b),
    .result    (dp_result),
    .cand_flags(dp_cand),
    .mask      (dp_mask)
  );

  // Stage 1 captures operands on accept; flush kills whatever it holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_ADD;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (s1_load) begin
        s1_valid <= in_valid;
      end
      if (accept) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= alu_op_e'(in_op);
      end
    end
  end

  // Stage 2 holds the computed result stable until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_cand   <= '0;
      s2_mask   <= '0;
    end else begin
      if (flush) begin
        s2_valid <= 1'b0;
      end else if (s2_free) begin
        s2_valid <= s1_valid;
      end
      if (s2_free && s1_valid) begin
        s2_result <= dp_result;
        s2_cand   <= dp_cand;
        s2_mask   <= dp_mask;
      end
    end
  end

  // Flags commit on the output handshake, even when a flush coincides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else if (out_fire) begin
      flag_q <= (flag_q & ~s2_mask) | (s2_cand & s2_mask);
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2_result;
  assign out_flag   = flag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: a saturating and a wrapping instance share
// stimulus; an independent integer model predicts results and flags.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, RED = 3'd3;
  localparam logic [2:0] SLL = 3'd4, SRA = 3'd5, ROR = 3'd6, PADDSB = 3'd7;

  typedef struct {
    logic [15:0] res;
    logic [15:0] res_w;
    logic [2:0]  mask;
    logic [2:0]  cand;
    logic [2:0]  cand_w;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic        in_ready, out_valid, in_ready_w, out_valid_w;
  logic [15:0] out_result, out_result_w;
  logic [2:0]  out_flag, out_flag_w;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pushes = 0;
  int          pops = 0;
  int          last_lat = 0;
  logic [15:0] last_res = '0;
  logic [15:0] last_res_w = '0;
  logic [2:0]  mflag = '0;
  logic [2:0]  mflag_w = '0;
  exp_t        sb[$];

  alu_pipe #(.WIDTH(16), .LANE(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flag(out_flag)
  );

  alu_pipe #(.WIDTH(16), .LANE(4), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_result(out_result_w), .out_flag(out_flag_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model written with integer arithmetic; flags are {Z,V,N}.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                input bit sat, output logic [15:0] res,
                                output logic [2:0] mask, output logic [2:0] cand);
    int sa, sb_i, s, amt, x, y;
    bit ovf;
    logic [15:0] r;
    logic signed [7:0] bt;
    logic signed [3:0] nb;
    sa = int'($signed(a));
    sb_i = int'($signed(b));
    amt = int'(b[3:0]);
    ovf = 1'b0;
    r = '0;
    mask = 3'b000;
    case (op)
      ADD, SUB: begin
        s = (op == ADD) ? sa + sb_i : sa - sb_i;
        ovf = (s > 32767) || (s < -32768);
        if (sat && ovf) r = (s > 0) ? 16'h7FFF : 16'h8000;
        else r = s[15:0];
        mask = 3'b111;
      end
      XOR: begin r = a ^ b; mask = 3'b100; end
      RED: begin
        s = 0;
        for (int i = 0; i < 2; i++) begin
          bt = a[8*i +: 8]; s += int'(bt);
          bt = b[8*i +: 8]; s += int'(bt);
        end
        r = s[15:0];
      end
      SLL: begin r = a << amt; mask = 3'b100; end
      SRA: begin
        r = a;
        for (int i = 0; i < amt; i++) r = {r[15], r[15:1]};
        mask = 3'b100;
      end
      ROR: begin
        r = a;
        for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
        mask = 3'b100;
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          nb = a[4*i +: 4]; x = int'(nb);
          nb = b[4*i +: 4]; y = int'(nb);
          s = x + y;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = s[3:0];
        end
      end
    endcase
    res = r;
    cand = {(r == 16'h0000), ovf, r[15]};
  endfunction

  // Monitor: flag check, handshake pop/compare, flush kill, accept push.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("flag", {29'd0, out_flag}, {29'd0, mflag});
      checkOutput("flag_wrap", {29'd0, out_flag_w}, {29'd0, mflag_w});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", {16'd0, out_result}, {16'd0, e.res});
          checkOutput("result_wrap", {16'd0, out_result_w}, {16'd0, e.res_w});
          mflag   = (mflag & ~e.mask) | (e.cand & e.mask);
          mflag_w = (mflag_w & ~e.mask) | (e.cand_w & e.mask);
          last_res   = e.res;
          last_res_w = e.res_w;
          last_lat   = cyc - e.cyc;
          pops++;
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) begin
        model(in_op, in_a, in_b, 1'b1, e.res, e.mask, e.cand);
        model(in_op, in_a, in_b, 1'b0, e.res_w, e.mask, e.cand_w);
        e.cyc = cyc;
        sb.push_back(e);
        pushes++;
      end
    end
  end

  // Present one op and hold it until the pipeline accepts it.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    logic acc;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    in_valid = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", sb.size(), 32'd0);
  endtask

  initial begin
    int p0, q0;
    logic [2:0] fsave;
    bit done;

    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_result", {16'd0, out_result}, 32'd0);
    checkOutput("rst_out_flag", {29'd0, out_flag}, 32'd0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);

    applyStimulus(ADD, 16'h7000, 16'h2000);
    waitDrain();
    checkOutput("add_sat_res", {16'd0, last_res}, 32'h7FFF);
    checkOutput("add_wrap_res", {16'd0, last_res_w}, 32'h9000);
    checkOutput("add_sat_flag", {29'd0, out_flag}, 32'b010);
    checkOutput("add_wrap_flag", {29'd0, out_flag_w}, 32'b011);
    checkOutput("add_latency", last_lat, 32'd2);

    applyStimulus(SUB, 16'h0005, 16'h0005);
    waitDrain();
    checkOutput("sub_zero_res", {16'd0, last_res}, 32'h0000);
    checkOutput("sub_zero_flag", {29'd0, out_flag}, 32'b100);
    applyStimulus(RED, 16'h0102, 16'h0304);
    waitDrain();
    checkOutput("red_res", {16'd0, last_res}, 32'h000A);
    checkOutput("red_flag_kept", {29'd0, out_flag}, 32'b100);

    applyStimulus(PADDSB, 16'h7878, 16'h1111);
    waitDrain();
    checkOutput("paddsb_res", {16'd0, last_res}, 32'h7979);
    applyStimulus(ROR, 16'h8001, 16'h0004);
    waitDrain();
    checkOutput("ror_res", {16'd0, last_res}, 32'h1800);
    applyStimulus(SRA, 16'h8000, 16'h000F);
    waitDrain();
    checkOutput("sra_res", {16'd0, last_res}, 32'hFFFF);
    applyStimulus(SLL, 16'h0001, 16'h0010);
    waitDrain();
    checkOutput("sll_zero_amt", {16'd0, last_res}, 32'h0001);

    // Back-to-back stream with the consumer stalled at first.
    out_ready = 1'b0;
    p0 = pushes;
    q0 = pops;
    fork
      begin
        for (int i = 0; i < 6; i++)
          applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      end
      begin
        int n;
        n = 0;
        while (pushes - p0 < 2 && n < 20) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain();
    checkOutput("stream_count", pops - q0, 32'd6);

    // Random ops with a randomly stalling consumer.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++)
          applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    // Flush with two ops stalled in flight: neither may emerge.
    out_ready = 1'b0;
    q0 = pops;
    applyStimulus(ADD, 16'h0001, 16'h0002);
    applyStimulus(XOR, 16'h00FF, 16'h0F0F);
    fsave = mflag;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_flags", {29'd0, out_flag}, {29'd0, fsave});
    applyStimulus(SUB, 16'h000A, 16'h0003);
    waitDrain();
    checkOutput("after_flush_res", {16'd0, last_res}, 32'h0007);
    checkOutput("after_flush_lat", last_lat, 32'd2);
    checkOutput("flush_count", pops - q0, 32'd1);

    // Flush coinciding with an output handshake: the head op still commits.
    q0 = pops;
    applyStimulus(SUB, 16'h0003, 16'h0003);
    applyStimulus(ADD, 16'h0001, 16'h0001);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("flush_hs_count", pops - q0, 32'd1);
    checkOutput("flush_hs_flag", {29'd0, out_flag}, 32'b100);

    // Asynchronous reset mid-flight after flags were made nonzero.
    applyStimulus(ADD, 16'h7000, 16'h2000);
    waitDrain();
    out_ready = 1'b0;
    applyStimulus(XOR, 16'h1234, 16'h4321);
    applyStimulus(ADD, 16'h0010, 16'h0020);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_out_flag", {29'd0, out_flag}, 32'd0);
    checkOutput("async_out_result", {16'd0, out_result}, 32'd0);
    sb.delete();
    mflag = '0;
    mflag_w = '0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    applyStimulus(XOR, 16'hAAAA, 16'h5555);
    waitDrain();
    checkOutput("post_rst_res", {16'd0, last_res}, 32'hFFFF);
    checkOutput("post_rst_lat", last_lat, 32'd2);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
